// File: rtl/key_conditioner.sv
// Two-channel push-button conditioner: synchronise, debounce, report press/release
// edges, flag long holds and auto-repeat while a long hold continues.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic [1:0] key_n_i,
    output logic [1:0] key_pulse_o,
    output logic [1:0] key_rel_o,
    output logic [1:0] key_long_o,
    output logic [1:0] key_level_o
);

    localparam int unsigned NUM_KEYS = 2;
    localparam int unsigned DB_W     = 8;
    localparam int unsigned HOLD_W   = 11;
    localparam int unsigned REP_W    = 11;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_LONG  = 2'd2
    } state_e;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan

        logic [1:0]        sync_q,   sync_d;
        logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
        logic              level_q,  level_d;
        state_e            state_q,  state_d;
        logic [HOLD_W-1:0] hold_q,   hold_d;
        logic [REP_W-1:0]  rep_q,    rep_d;
        logic              pulse_q,  pulse_d;
        logic              rel_q,    rel_d;
        logic              long_q,   long_d;

        logic              key_pressed;
        logic              toggle;
        logic              rise;
        logic              fall;

        // State register; synchroniser idles at 1 so a held key debounces afresh after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q   <= 2'b11;
                db_cnt_q <= '0;
                level_q  <= 1'b0;
                state_q  <= ST_IDLE;
                hold_q   <= '0;
                rep_q    <= '0;
                pulse_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                sync_q   <= sync_d;
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
                state_q  <= state_d;
                hold_q   <= hold_d;
                rep_q    <= rep_d;
                pulse_q  <= pulse_d;
                rel_q    <= rel_d;
                long_q   <= long_d;
            end
        end

        // Debounce, then press/long/repeat sequencing on the debounced edges.
        always_comb begin
            sync_d      = {sync_q[0], key_n_i[i]};
            key_pressed = ~sync_q[1];
            db_cnt_d    = db_cnt_q;
            level_d     = level_q;
            toggle      = 1'b0;
            state_d     = state_q;
            hold_d      = hold_q;
            rep_d       = rep_q;
            pulse_d     = 1'b0;
            rel_d       = 1'b0;
            long_d      = long_q;

            if (key_pressed == level_q) begin
                db_cnt_d = '0;
            end else if (tick_i) begin
                if (db_cnt_q == DB_LAST) begin
                    toggle   = 1'b1;
                    level_d  = ~level_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            rise = toggle & ~level_q;
            fall = toggle & level_q;

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_PRESS;
                        hold_d  = '0;
                        pulse_d = 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (fall) begin
                        state_d = ST_IDLE;
                        rel_d   = 1'b1;
                        long_d  = 1'b0;
                    end else if (tick_i) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_LONG;
                            hold_d  = HOLD_MAX;
                            rep_d   = '0;
                            long_d  = 1'b1;
                            pulse_d = 1'b1;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                ST_LONG: begin
                    // A release completing on a repeat tick wins; no repeat pulse then.
                    if (fall) begin
                        state_d = ST_IDLE;
                        rel_d   = 1'b1;
                        long_d  = 1'b0;
                    end else if (tick_i) begin
                        if (rep_q == REP_LAST) begin
                            rep_d   = '0;
                            pulse_d = 1'b1;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    long_d  = 1'b0;
                end
            endcase
        end

        assign key_pulse_o[i] = pulse_q;
        assign key_rel_o[i]   = rel_q;
        assign key_long_o[i]  = long_q;
        assign key_level_o[i] = level_q;

    end : g_chan

endmodule : key_conditioner

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity, all cycles
// compared against a time-based reference model of debounce, long hold and repeat.
module tb_key_conditioner;

    localparam int DEB      = 4;
    localparam int LONG     = 10;
    localparam int REP      = 3;
    localparam int TICK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [1:0] key_n;
    logic [1:0] key_pulse, key_rel, key_long, key_level;

    key_conditioner #(
        .DEBOUNCE_MS (DEB),
        .LONG_MS     (LONG),
        .REPEAT_MS   (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_i      (tick),
        .key_n_i     (key_n),
        .key_pulse_o (key_pulse),
        .key_rel_o   (key_rel),
        .key_long_o  (key_long),
        .key_level_o (key_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: raw key history, debounced level, elapsed ticks of disagreement and of hold.
    logic [1:0] m_hist1, m_hist2;
    logic [1:0] m_level, e_pulse, e_rel, e_long;
    int         m_diff [2];
    int         m_held [2];

    // Event bookkeeping for the directed scenarios.
    int npulse [2], nrel [2], nlong [2];
    int first_pulse [2], first_rel [2], first_long [2];
    int act1, both_pulse, both_rel, pulse_rel_same, seg_start;

    logic [1:0] rk;
    int         rlen;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist1 = 2'b11;
        m_hist2 = 2'b11;
        m_level = 2'b00;
        e_pulse = 2'b00;
        e_rel   = 2'b00;
        e_long  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_diff[i] = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [1:0] key, input logic t);
        logic pressed, old;
        for (int i = 0; i < 2; i++) begin
            pressed    = ~m_hist2[i];
            old        = m_level[i];
            e_pulse[i] = 1'b0;
            e_rel[i]   = 1'b0;
            if (pressed == m_level[i]) begin
                m_diff[i] = 0;
            end else if (t) begin
                m_diff[i]++;
                if (m_diff[i] == DEB) begin
                    m_level[i] = ~m_level[i];
                    m_diff[i]  = 0;
                end
            end
            if (m_level[i] && !old) begin
                m_held[i]  = 0;
                e_pulse[i] = 1'b1;
            end else if (!m_level[i] && old) begin
                e_rel[i]  = 1'b1;
                e_long[i] = 1'b0;
            end else if (m_level[i] && t) begin
                m_held[i]++;
                if (m_held[i] == LONG) begin
                    e_pulse[i] = 1'b1;
                    e_long[i]  = 1'b1;
                end else if (m_held[i] > LONG && ((m_held[i] - LONG) % REP) == 0) begin
                    e_pulse[i] = 1'b1;
                end
            end
        end
        m_hist2 = m_hist1;
        m_hist1 = key;
    endtask

    task automatic clr();
        seg_start      = cyc;
        act1           = 0;
        both_pulse     = 0;
        both_rel       = 0;
        pulse_rel_same = 0;
        for (int i = 0; i < 2; i++) begin
            npulse[i]      = 0;
            nrel[i]        = 0;
            nlong[i]       = 0;
            first_pulse[i] = -1;
            first_rel[i]   = -1;
            first_long[i]  = -1;
        end
    endtask

    task automatic track();
        for (int i = 0; i < 2; i++) begin
            if (key_pulse[i] === 1'b1) begin
                npulse[i]++;
                if (first_pulse[i] < 0) first_pulse[i] = cyc - seg_start;
            end
            if (key_rel[i] === 1'b1) begin
                nrel[i]++;
                if (first_rel[i] < 0) first_rel[i] = cyc - seg_start;
            end
            if (key_long[i] === 1'b1) begin
                nlong[i]++;
                if (first_long[i] < 0) first_long[i] = cyc - seg_start;
            end
        end
        if ((key_pulse[1] | key_rel[1] | key_long[1] | key_level[1]) === 1'b1) act1++;
        if (key_pulse === 2'b11) both_pulse++;
        if (key_rel === 2'b11) both_rel++;
        if ((key_pulse[0] & key_rel[0]) === 1'b1) pulse_rel_same++;
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic step(input logic [1:0] key);
        logic t;
        t     = ((cyc % TICK_DIV) == TICK_DIV - 1);
        key_n = key;
        tick  = t;
        @(posedge clk);
        if (rst_n) model_edge(key, t);
        else       model_reset();
        #1;
        chk("pulse", key_pulse, e_pulse);
        chk("rel",   key_rel,   e_rel);
        chk("long",  key_long,  e_long);
        chk("level", key_level, m_level);
        track();
        cyc++;
    endtask

    task automatic run(input logic [1:0] key, input int n);
        for (int j = 0; j < n; j++) step(key);
    endtask

    task automatic align(input logic [1:0] key);
        while ((cyc % TICK_DIV) != 0) step(key);
    endtask

    task automatic assert_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_pulse"}, key_pulse, 2'b00);
        chk({tag, "_rel"},   key_rel,   2'b00);
        chk({tag, "_long"},  key_long,  2'b00);
        chk({tag, "_level"}, key_level, 2'b00);
    endtask

    initial begin
        rst_n = 1'b1;
        key_n = 2'b11;
        tick  = 1'b0;
        model_reset();
        clr();
        #2;
        assert_reset("por");
        run(2'b11, 4);
        rst_n = 1'b1;
        run(2'b11, 4);

        // Short press on key 1: press edge after 4 ticks, release after 4 more, no long hold.
        align(2'b11);
        clr();
        run(2'b10, 64);
        chk_int("k1_press_latency", first_pulse[0], 4 * TICK_DIV - 1);
        chk_int("k1_press_count", npulse[0], 1);
        run(2'b11, 64);
        chk_int("k1_rel_latency", first_rel[0], 64 + 4 * TICK_DIV - 1);
        chk_int("k1_rel_count", nrel[0], 1);
        chk_int("k1_no_long", nlong[0], 0);
        chk_int("k1_ch1_quiet", act1, 0);

        // Bounces of three ticks on key 2 never qualify.
        align(2'b11);
        clr();
        for (int b = 0; b < 5; b++) begin
            run(2'b01, 24);
            run(2'b11, 24);
        end
        chk_int("bounce_ch1_quiet", act1, 0);
        chk_int("bounce_ch0_quiet", npulse[0] + nrel[0], 0);

        // Long hold: pulses at hold ticks 0, 10, 13, 16, 19; long from hold tick 10.
        align(2'b11);
        clr();
        run(2'b10, 4 * TICK_DIV + 20 * TICK_DIV);
        chk_int("long_pulse_count", npulse[0], 5);
        chk_int("long_rise", first_long[0], 4 * TICK_DIV - 1 + 10 * TICK_DIV);
        run(2'b11, 64);
        chk_int("long_rel_count", nrel[0], 1);

        // Both keys pressed together behave identically and cycle-aligned.
        align(2'b11);
        clr();
        run(2'b00, 64);
        chk_int("both_pulse", both_pulse, 1);
        chk_int("both_pulse_ch1", npulse[1], 1);
        run(2'b11, 64);
        chk_int("both_rel", both_rel, 1);

        // Reset at hold tick 12 of a long press: no release, fresh press afterwards.
        align(2'b11);
        clr();
        run(2'b10, 4 * TICK_DIV + 12 * TICK_DIV);
        chk_int("pre_rst_long", key_long[0], 1);
        clr();
        assert_reset("midrst");
        run(2'b10, 5);
        align(2'b10);
        seg_start = cyc;
        rst_n     = 1'b1;
        run(2'b10, 64);
        chk_int("midrst_no_rel", nrel[0], 0);
        chk_int("midrst_repress", first_pulse[0], 4 * TICK_DIV - 1);
        run(2'b11, 64);

        // Release completing on a repeat tick: release wins, repeat suppressed.
        align(2'b11);
        clr();
        run(2'b10, 4 * TICK_DIV + 18 * TICK_DIV);
        chk_int("coinc_press_pulses", npulse[0], 4);
        clr();
        run(2'b11, 64);
        chk_int("coinc_rel_latency", first_rel[0], 4 * TICK_DIV - 1);
        chk_int("coinc_pulses", npulse[0], 1);
        chk_int("coinc_overlap", pulse_rel_same, 0);

        // Random activity on both channels, with occasional resets.
        for (int s = 0; s < 60; s++) begin
            rk   = 2'($urandom_range(0, 3));
            rlen = ((s % 4) == 0) ? int'($urandom_range(100, 220)) : int'($urandom_range(1, 50));
            run(rk, rlen);
            if ((s % 15) == 14) begin
                assert_reset("rndrst");
                run(rk, 3);
                rst_n = 1'b1;
            end
        end
        run(2'b11, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_key_conditioner
